// File: rtl/fle_cfg_pkg.sv
// Shared constants, state encoding and pad-bit mask for the fle configuration loader.
package fle_cfg_pkg;

   localparam int unsigned MEM_SIZE  = 47;
   localparam int unsigned WORD_W    = 8;
   localparam int unsigned NUM_WORDS = (MEM_SIZE + WORD_W - 1) / WORD_W;
   localparam int unsigned SHADOW_W  = NUM_WORDS * WORD_W;
   localparam int unsigned CNT_W     = $clog2(NUM_WORDS + 1);

   typedef enum logic [2:0] {
      StIdle,
      StLoad,
      StCheck,
      StCommit,
      StError
   } cfg_state_e;

   // Marks shadow bits beyond MEM_SIZE that exist only to fill the last word.
   function automatic logic [SHADOW_W-1:0] pad_mask_f();
      logic [SHADOW_W-1:0] m;
      m = '0;
      for (int unsigned i = 0; i < SHADOW_W; i++) begin
         m[i] = (i >= MEM_SIZE);
      end
      return m;
   endfunction

   localparam logic [SHADOW_W-1:0] PAD_MASK = pad_mask_f();

endpackage

// File: rtl/fle_cfg_shadow_reg.sv
// Shadow register for one configuration frame, pad-bit check and atomic commit to the
// memory bits that drive the fle.
module fle_cfg_shadow_reg
   import fle_cfg_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                clear_i,
   input  logic                wr_en_i,
   input  logic [CNT_W-1:0]    wr_idx_i,
   input  logic [WORD_W-1:0]   wr_data_i,
   input  logic                commit_i,
   output logic                pad_err_o,
   output logic [MEM_SIZE-1:0] mem_out_o,
   output logic [MEM_SIZE-1:0] mem_outb_o
);

   logic [SHADOW_W-1:0] shadow_q, shadow_d;
   logic [MEM_SIZE-1:0] mem_q, mem_d;
   logic [MEM_SIZE-1:0] memb_q, memb_d;

   always_comb begin
      shadow_d = shadow_q;
      mem_d    = mem_q;
      memb_d   = memb_q;
      if (clear_i) begin
         shadow_d = '0;
      end else if (wr_en_i) begin
         for (int unsigned w = 0; w < NUM_WORDS; w++) begin
            if (wr_idx_i == CNT_W'(w)) begin
               shadow_d[w*WORD_W +: WORD_W] = wr_data_i;
            end
         end
      end
      // The complement is registered separately so both buses switch on the same edge.
      if (commit_i) begin
         mem_d  = shadow_q[MEM_SIZE-1:0];
         memb_d = ~shadow_q[MEM_SIZE-1:0];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         shadow_q <= '0;
         mem_q    <= '0;
         memb_q   <= '1;
      end else begin
         shadow_q <= shadow_d;
         mem_q    <= mem_d;
         memb_q   <= memb_d;
      end
   end

   assign pad_err_o  = |(shadow_q & PAD_MASK);
   assign mem_out_o  = mem_q;
   assign mem_outb_o = memb_q;

endmodule

// File: rtl/fle_config_loader.sv
// Configuration front-end for the fle tile: streams words into a shadow register, verifies
// an XOR checksum and commits the whole frame at once.
module fle_config_loader
   import fle_cfg_pkg::*;
(
   input  logic                fle_clk,
   input  logic                fle_reset,
   input  logic                cfg_start,
   input  logic                cfg_valid,
   input  logic [WORD_W-1:0]   cfg_data,
   output logic                cfg_ready,
   output logic [MEM_SIZE-1:0] mem_out,
   output logic [MEM_SIZE-1:0] mem_outb,
   output logic                cfg_done,
   output logic                cfg_error
);

   cfg_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [WORD_W-1:0] csum_q, csum_d;
   logic              err_q, err_d;
   logic              clear, wr_en, commit, pad_err;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      csum_d    = csum_q;
      err_d     = err_q;
      cfg_ready = 1'b0;
      cfg_done  = 1'b0;
      clear     = 1'b0;
      wr_en     = 1'b0;
      commit    = 1'b0;
      // A start pulse outside COMMIT/ERROR (re)opens a frame and drops any same-cycle word.
      if (cfg_start && (state_q inside {StIdle, StLoad, StCheck})) begin
         state_d = StLoad;
         cnt_d   = '0;
         csum_d  = '0;
         err_d   = 1'b0;
         clear   = 1'b1;
      end
      unique case (state_q)
         StIdle: ;
         StLoad: begin
            cfg_ready = 1'b1;
            if (!cfg_start && cfg_valid) begin
               wr_en  = 1'b1;
               csum_d = csum_q ^ cfg_data;
               cnt_d  = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(NUM_WORDS - 1)) begin
                  state_d = StCheck;
               end
            end
         end
         StCheck: begin
            cfg_ready = 1'b1;
            if (!cfg_start && cfg_valid) begin
               if (((csum_q ^ cfg_data) == '0) && !pad_err) begin
                  state_d = StCommit;
               end else begin
                  state_d = StError;
               end
            end
         end
         StCommit: begin
            commit   = 1'b1;
            cfg_done = 1'b1;
            state_d  = StIdle;
         end
         StError: begin
            err_d   = 1'b1;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge fle_clk) begin
      if (fle_reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         csum_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         csum_q  <= csum_d;
         err_q   <= err_d;
      end
   end

   assign cfg_error = err_q;

   fle_cfg_shadow_reg u_shadow (
      .clk_i      (fle_clk),
      .rst_i      (fle_reset),
      .clear_i    (clear),
      .wr_en_i    (wr_en),
      .wr_idx_i   (cnt_q),
      .wr_data_i  (cfg_data),
      .commit_i   (commit),
      .pad_err_o  (pad_err),
      .mem_out_o  (mem_out),
      .mem_outb_o (mem_outb)
   );

endmodule

// File: tb/tb_fle_config_loader.sv
// Directed bench for fle_config_loader: commits, checksum and pad errors, abort, gaps, reset.
module tb_fle_config_loader;

   localparam logic [46:0] ONES = '1;
   localparam logic [46:0] ZERO = '0;
   localparam logic [46:0] BIT0 = 47'h1;
   localparam logic [47:0] FRAME_BIT0 = 48'h000000000001;
   localparam logic [47:0] FRAME_ONES = 48'h7FFFFFFFFFFF;
   localparam logic [47:0] FRAME_PAD  = 48'h800000000000;
   localparam logic [47:0] FRAME_A    = 48'h665544332211;
   localparam logic [47:0] FRAME_B    = 48'h3C9A78563412;

   logic        fle_clk = 1'b0;
   logic        fle_reset, cfg_start, cfg_valid;
   logic [7:0]  cfg_data;
   logic        cfg_ready, cfg_done, cfg_error;
   logic [46:0] mem_out, mem_outb;

   int total = 0;
   int bad   = 0;

   fle_config_loader dut (
      .fle_clk   (fle_clk),
      .fle_reset (fle_reset),
      .cfg_start (cfg_start),
      .cfg_valid (cfg_valid),
      .cfg_data  (cfg_data),
      .cfg_ready (cfg_ready),
      .mem_out   (mem_out),
      .mem_outb  (mem_outb),
      .cfg_done  (cfg_done),
      .cfg_error (cfg_error)
   );

   always #5 fle_clk = ~fle_clk;

   task automatic tick();
      @(posedge fle_clk);
      #1;
   endtask

   task automatic pulse_start();
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] d);
      int n;
      n = 0;
      cfg_valid = 1'b1;
      cfg_data  = d;
      while (!cfg_ready && n < 16) begin
         tick();
         n++;
      end
      total++;
      if (cfg_ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_timeout: cfg_ready=%b required 1 for word %h", cfg_ready, d);
      end
      tick();
      cfg_valid = 1'b0;
      cfg_data  = '0;
   endtask

   task automatic send_words(input logic [47:0] w, input logic [7:0] cs, input bit gaps);
      for (int k = 0; k < 6; k++) begin
         if (gaps) repeat ($urandom_range(0, 3)) tick();
         send_word(w[k*8 +: 8]);
      end
      if (gaps) repeat ($urandom_range(0, 3)) tick();
      send_word(cs);
   endtask

   task automatic test_reset();
      fle_reset = 1'b1;
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = '0;
      repeat (3) tick();
      fle_reset = 1'b0;
      total += 5;
      if (mem_out !== ZERO) begin
         bad++; $display("FAIL reset_mem_out: got %h required %h", mem_out, ZERO);
      end
      if (mem_outb !== ONES) begin
         bad++; $display("FAIL reset_mem_outb: got %h required %h", mem_outb, ONES);
      end
      if (cfg_ready !== 1'b0) begin
         bad++; $display("FAIL reset_ready: got %b required 0", cfg_ready);
      end
      if (cfg_done !== 1'b0) begin
         bad++; $display("FAIL reset_done: got %b required 0", cfg_done);
      end
      if (cfg_error !== 1'b0) begin
         bad++; $display("FAIL reset_error: got %b required 0", cfg_error);
      end
   endtask

   task automatic test_single_bit();
      pulse_start();
      send_words(FRAME_BIT0, 8'h01, 1'b0);
      total += 5;
      if (cfg_done !== 1'b1) begin
         bad++; $display("FAIL bit0_done: got %b required 1", cfg_done);
      end
      tick();
      if (cfg_done !== 1'b0) begin
         bad++; $display("FAIL bit0_done_pulse: got %b required 0", cfg_done);
      end
      if (mem_out !== BIT0) begin
         bad++; $display("FAIL bit0_mem_out: got %h required %h", mem_out, BIT0);
      end
      if (mem_outb !== ~BIT0) begin
         bad++; $display("FAIL bit0_mem_outb: got %h required %h", mem_outb, ~BIT0);
      end
      if (cfg_error !== 1'b0) begin
         bad++; $display("FAIL bit0_error: got %b required 0", cfg_error);
      end
   endtask

   task automatic test_all_ones();
      pulse_start();
      send_words(FRAME_ONES, 8'h80, 1'b0);
      total += 5;
      if (cfg_done !== 1'b1) begin
         bad++; $display("FAIL ones_done: got %b required 1", cfg_done);
      end
      // Start during COMMIT must be ignored, leaving the loader idle.
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      if (cfg_ready !== 1'b0) begin
         bad++; $display("FAIL commit_start_ignored: cfg_ready=%b required 0", cfg_ready);
      end
      if (mem_out !== ONES) begin
         bad++; $display("FAIL ones_mem_out: got %h required %h", mem_out, ONES);
      end
      if (mem_outb !== ZERO) begin
         bad++; $display("FAIL ones_mem_outb: got %h required %h", mem_outb, ZERO);
      end
      if (cfg_error !== 1'b0) begin
         bad++; $display("FAIL ones_error: got %b required 0", cfg_error);
      end
   endtask

   task automatic test_bad_checksum();
      pulse_start();
      send_words(FRAME_BIT0, 8'h00, 1'b0);
      total += 5;
      if (cfg_done !== 1'b0) begin
         bad++; $display("FAIL badcs_done: got %b required 0", cfg_done);
      end
      tick();
      if (cfg_error !== 1'b1) begin
         bad++; $display("FAIL badcs_error: got %b required 1", cfg_error);
      end
      if (cfg_done !== 1'b0) begin
         bad++; $display("FAIL badcs_no_done: got %b required 0", cfg_done);
      end
      if (mem_out !== ONES) begin
         bad++; $display("FAIL badcs_mem_kept: got %h required %h", mem_out, ONES);
      end
      pulse_start();
      if (cfg_error !== 1'b0) begin
         bad++; $display("FAIL start_clears_error: got %b required 0", cfg_error);
      end
   endtask

   task automatic test_pad();
      pulse_start();
      send_words(FRAME_PAD, 8'h80, 1'b0);
      tick();
      total += 3;
      if (cfg_error !== 1'b1) begin
         bad++; $display("FAIL pad_error: got %b required 1", cfg_error);
      end
      if (mem_out !== ONES) begin
         bad++; $display("FAIL pad_mem_kept: got %h required %h", mem_out, ONES);
      end
      if (mem_outb !== ZERO) begin
         bad++; $display("FAIL pad_memb_kept: got %h required %h", mem_outb, ZERO);
      end
   endtask

   task automatic test_idle_valid();
      cfg_valid = 1'b1;
      cfg_data  = 8'h55;
      repeat (3) tick();
      total += 3;
      if (cfg_ready !== 1'b0) begin
         bad++; $display("FAIL idle_ready: got %b required 0", cfg_ready);
      end
      cfg_valid = 1'b0;
      cfg_data  = '0;
      tick();
      if (mem_out !== ONES) begin
         bad++; $display("FAIL idle_mem_kept: got %h required %h", mem_out, ONES);
      end
      if (cfg_error !== 1'b1) begin
         bad++; $display("FAIL idle_error_kept: got %b required 1", cfg_error);
      end
   endtask

   task automatic test_abort();
      pulse_start();
      send_word(8'hAA);
      send_word(8'hBB);
      send_word(8'hCC);
      // Abort with a word presented in the same cycle; that word must be dropped.
      cfg_start = 1'b1;
      cfg_valid = 1'b1;
      cfg_data  = 8'hFF;
      tick();
      cfg_start = 1'b0;
      cfg_valid = 1'b0;
      total += 2;
      if (mem_out !== ONES) begin
         bad++; $display("FAIL abort_mem_kept: got %h required %h", mem_out, ONES);
      end
      send_words(FRAME_A, 8'h77, 1'b0);
      if (cfg_done !== 1'b1) begin
         bad++; $display("FAIL abort_done: got %b required 1", cfg_done);
      end
      tick();
      total += 2;
      if (mem_out !== FRAME_A[46:0]) begin
         bad++; $display("FAIL abort_mem_out: got %h required %h", mem_out, FRAME_A[46:0]);
      end
      if (mem_outb !== ~FRAME_A[46:0]) begin
         bad++; $display("FAIL abort_mem_outb: got %h required %h", mem_outb, ~FRAME_A[46:0]);
      end
   endtask

   task automatic test_gaps();
      pulse_start();
      send_words(FRAME_B, 8'hAE, 1'b1);
      total += 3;
      if (cfg_done !== 1'b1) begin
         bad++; $display("FAIL gaps_done: got %b required 1", cfg_done);
      end
      tick();
      if (mem_out !== FRAME_B[46:0]) begin
         bad++; $display("FAIL gaps_mem_out: got %h required %h", mem_out, FRAME_B[46:0]);
      end
      if (cfg_error !== 1'b0) begin
         bad++; $display("FAIL gaps_error: got %b required 0", cfg_error);
      end
   endtask

   task automatic test_reset_mid_frame();
      pulse_start();
      send_word(8'h01);
      send_word(8'h02);
      fle_reset = 1'b1;
      tick();
      fle_reset = 1'b0;
      total += 4;
      if (mem_out !== ZERO) begin
         bad++; $display("FAIL midreset_mem_out: got %h required %h", mem_out, ZERO);
      end
      if (mem_outb !== ONES) begin
         bad++; $display("FAIL midreset_mem_outb: got %h required %h", mem_outb, ONES);
      end
      if (cfg_ready !== 1'b0) begin
         bad++; $display("FAIL midreset_ready: got %b required 0", cfg_ready);
      end
      pulse_start();
      send_words(FRAME_BIT0, 8'h01, 1'b0);
      tick();
      if (mem_out !== BIT0) begin
         bad++; $display("FAIL midreset_recommit: got %h required %h", mem_out, BIT0);
      end
   endtask

   initial begin
      test_reset();
      test_single_bit();
      test_all_ones();
      test_bad_checksum();
      test_pad();
      test_idle_valid();
      test_abort();
      test_gaps();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
      $fatal(1);
   end

endmodule
